// File: rtl/kernel_cra_responder.sv
// rtl/kernel_cra_responder.sv - Avalon-MM CRA responder with kernel invocation sequencer
//
// Purpose:
//   Decodes single-beat 64-bit CRA reads and writes into a small register file.
//   Sequences one kernel invocation through IDLE/RUNNING/DONE.
//   Raises the kernel interrupt when the run completes.
//
// Ports:
//   kernel_clk_clk           sole clock (rising edge)
//   kernel_reset_reset_n     synchronous active-low reset
//   opencl_freeze            holds off all CRA transfers while high
//   kernel_cra_*             Avalon-MM responder (address[5:3] selects the word)
//   kernel_irq_irq           registered DONE & IRQ_EN
//   kernel_start             one-cycle start pulse to the datapath
//   kernel_item_done         one pulse per completed work item
module kernel_cra_responder #(
  parameter logic [63:0] ID_VALUE   = 64'h4F43_4C5F_4352_4131,
  parameter int          WORK_WIDTH = 32
) (
  input  logic        kernel_clk_clk,
  input  logic        kernel_reset_reset_n,
  input  logic        opencl_freeze,
  input  logic [29:0] kernel_cra_address,
  input  logic        kernel_cra_read,
  input  logic        kernel_cra_write,
  input  logic [63:0] kernel_cra_writedata,
  input  logic [7:0]  kernel_cra_byteenable,
  input  logic        kernel_cra_burstcount,
  input  logic        kernel_cra_debugaccess,
  output logic        kernel_cra_waitrequest,
  output logic [63:0] kernel_cra_readdata,
  output logic        kernel_cra_readdatavalid,
  output logic        kernel_irq_irq,
  output logic        kernel_start,
  input  logic        kernel_item_done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  waitreq_q, waitreq_d;
  logic                  irq_en_q, irq_en_d;
  logic                  done_q, done_d;
  logic [WORK_WIDTH-1:0] work_size_q, work_size_d;
  logic [63:0]           cycle_count_q, cycle_count_d;
  logic [WORK_WIDTH-1:0] completed_q, completed_d;
  logic [63:0]           arg0_q, arg0_d;
  logic [63:0]           arg1_q, arg1_d;
  logic                  kernel_start_q, kernel_start_d;
  logic                  irq_q, irq_d;
  logic                  rd_vld_s1_q, rd_vld_s1_d;
  logic [63:0]           rd_data_s1_q, rd_data_s1_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [63:0]           rd_data_q, rd_data_d;

  logic                  acc_wr;
  logic                  acc_rd;
  logic                  addr_ok;
  logic [2:0]            word;
  logic                  ctrl_b0;
  logic                  start_req;
  logic                  soft_rst;
  logic                  w1c_done;
  logic [WORK_WIDTH-1:0] completed_inc;
  logic [63:0]           rd_mux;

  // Sideband inputs with no function in this responder.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, kernel_cra_burstcount, kernel_cra_debugaccess,
                           kernel_cra_address[2:0]};

  function automatic logic [63:0] be_merge(input logic [63:0] old_v,
                                           input logic [63:0] new_v,
                                           input logic [7:0]  be);
    logic [63:0] r;
    r = old_v;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

  // Transfer decode. A simultaneous read and write performs only the write.
  always_comb begin
    acc_wr        = kernel_cra_write & ~waitreq_q;
    acc_rd        = kernel_cra_read & ~kernel_cra_write & ~waitreq_q;
    addr_ok       = (kernel_cra_address[29:6] == 24'd0);
    word          = kernel_cra_address[5:3];
    ctrl_b0       = acc_wr & addr_ok & (word == 3'd0) & kernel_cra_byteenable[0];
    start_req     = ctrl_b0 & kernel_cra_writedata[0];
    soft_rst      = ctrl_b0 & kernel_cra_writedata[2];
    w1c_done      = acc_wr & addr_ok & (word == 3'd1) & kernel_cra_byteenable[0]
                    & kernel_cra_writedata[1];
    completed_inc = completed_q + 1'b1;
  end

  // FSM: state register
  always_ff @(posedge kernel_clk_clk) begin
    if (!kernel_reset_reset_n) state_q <= ST_IDLE;
    else                       state_q <= state_d;
  end

  // FSM: next state. SOFT_RST overrides every other event.
  always_comb begin
    state_d = state_q;
    if (soft_rst) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_req) state_d = (work_size_q == '0) ? ST_DONE : ST_RUNNING;
        end
        ST_RUNNING: begin
          // >= guards against WORK_SIZE being lowered mid-run.
          if (kernel_item_done && (completed_inc >= work_size_q)) state_d = ST_DONE;
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs and register file next values
  always_comb begin
    waitreq_d      = opencl_freeze;
    kernel_start_d = (state_q == ST_IDLE) && (state_d == ST_RUNNING);
    irq_d          = done_q & irq_en_q;

    irq_en_d = irq_en_q;
    if (ctrl_b0) irq_en_d = kernel_cra_writedata[1];

    // Setting DONE on entry wins over a same-cycle W1C; SOFT_RST wins over both.
    done_d = done_q;
    if (w1c_done) done_d = 1'b0;
    if ((state_q != ST_DONE) && (state_d == ST_DONE)) done_d = 1'b1;
    if (soft_rst) done_d = 1'b0;

    completed_d   = completed_q;
    cycle_count_d = cycle_count_q;
    if (soft_rst || ((state_q == ST_IDLE) && start_req)) begin
      completed_d   = '0;
      cycle_count_d = '0;
    end else if (state_q == ST_RUNNING) begin
      if (kernel_item_done) completed_d = completed_inc;
      if (cycle_count_q != '1) cycle_count_d = cycle_count_q + 64'd1;
    end

    work_size_d = work_size_q;
    arg0_d      = arg0_q;
    arg1_d      = arg1_q;
    if (acc_wr && addr_ok) begin
      case (word)
        3'd2: begin
          for (int i = 0; i < WORK_WIDTH; i++) begin
            if (kernel_cra_byteenable[i/8]) work_size_d[i] = kernel_cra_writedata[i];
          end
        end
        3'd5:    arg0_d = be_merge(arg0_q, kernel_cra_writedata, kernel_cra_byteenable);
        3'd6:    arg1_d = be_merge(arg1_q, kernel_cra_writedata, kernel_cra_byteenable);
        default: ;
      endcase
    end

    // Two-stage read pipeline: capture at acceptance, present one cycle later.
    rd_vld_s1_d  = acc_rd;
    rd_data_s1_d = acc_rd ? rd_mux : rd_data_s1_q;
    rd_vld_d     = rd_vld_s1_q;
    rd_data_d    = rd_vld_s1_q ? rd_data_s1_q : rd_data_q;
  end

  // Read data mux over current register values
  always_comb begin
    rd_mux = '0;
    if (addr_ok) begin
      case (word)
        3'd0: rd_mux = {62'd0, irq_en_q, 1'b0};
        3'd1: rd_mux = {62'd0, done_q, (state_q == ST_RUNNING)};
        3'd2: rd_mux = 64'(work_size_q);
        3'd3: rd_mux = cycle_count_q;
        3'd4: rd_mux = 64'(completed_q);
        3'd5: rd_mux = arg0_q;
        3'd6: rd_mux = arg1_q;
        3'd7: rd_mux = ID_VALUE;
        default: rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge kernel_clk_clk) begin
    if (!kernel_reset_reset_n) begin
      waitreq_q      <= 1'b1;
      irq_en_q       <= 1'b0;
      done_q         <= 1'b0;
      work_size_q    <= '0;
      cycle_count_q  <= '0;
      completed_q    <= '0;
      arg0_q         <= '0;
      arg1_q         <= '0;
      kernel_start_q <= 1'b0;
      irq_q          <= 1'b0;
      rd_vld_s1_q    <= 1'b0;
      rd_data_s1_q   <= '0;
      rd_vld_q       <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      waitreq_q      <= waitreq_d;
      irq_en_q       <= irq_en_d;
      done_q         <= done_d;
      work_size_q    <= work_size_d;
      cycle_count_q  <= cycle_count_d;
      completed_q    <= completed_d;
      arg0_q         <= arg0_d;
      arg1_q         <= arg1_d;
      kernel_start_q <= kernel_start_d;
      irq_q          <= irq_d;
      rd_vld_s1_q    <= rd_vld_s1_d;
      rd_data_s1_q   <= rd_data_s1_d;
      rd_vld_q       <= rd_vld_d;
      rd_data_q      <= rd_data_d;
    end
  end

  assign kernel_cra_waitrequest   = waitreq_q;
  assign kernel_cra_readdata      = rd_data_q;
  assign kernel_cra_readdatavalid = rd_vld_q;
  assign kernel_irq_irq           = irq_q;
  assign kernel_start             = kernel_start_q;

endmodule

// File: tb/tb_kernel_cra_responder.sv
// tb/tb_kernel_cra_responder.sv - self-checking bench for kernel_cra_responder
module tb_kernel_cra_responder;

  localparam logic [63:0] ID = 64'h4F43_4C5F_4352_4131;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        freeze = 1'b0;
  logic [29:0] addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [63:0] wdata = '0;
  logic [7:0]  be = '0;
  logic        waitreq;
  logic [63:0] rdata;
  logic        rvalid;
  logic        irq;
  logic        kstart;
  logic        item_done = 1'b0;

  int n_checks = 0;
  int n_pass = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (kstart) start_cnt <= start_cnt + 1;

  kernel_cra_responder dut (
    .kernel_clk_clk           (clk),
    .kernel_reset_reset_n     (resetn),
    .opencl_freeze            (freeze),
    .kernel_cra_address       (addr),
    .kernel_cra_read          (rd),
    .kernel_cra_write         (wr),
    .kernel_cra_writedata     (wdata),
    .kernel_cra_byteenable    (be),
    .kernel_cra_burstcount    (1'b1),
    .kernel_cra_debugaccess   (1'b0),
    .kernel_cra_waitrequest   (waitreq),
    .kernel_cra_readdata      (rdata),
    .kernel_cra_readdatavalid (rvalid),
    .kernel_irq_irq           (irq),
    .kernel_start             (kstart),
    .kernel_item_done         (item_done)
  );

  typedef struct {
    bit          is_wr;
    logic [29:0] a;
    logic [63:0] d;
    logic [7:0]  b;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (waitreq && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (waitreq) chk("waitreq_timeout", {63'd0, waitreq}, 64'd0);
  endtask

  task automatic cra_write(input logic [29:0] a, input logic [63:0] d, input logic [7:0] b);
    wait_ready();
    addr = a; wdata = d; be = b; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic cra_read(input string name, input logic [29:0] a, input logic [63:0] exp,
                          input bit do_cmp, output logic [63:0] got);
    wait_ready();
    addr = a; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    chk({name, "_early"}, {63'd0, rvalid}, 64'd0);
    @(posedge clk); #1;
    chk({name, "_vld"}, {63'd0, rvalid}, 64'd1);
    got = rdata;
    if (do_cmp) chk(name, rdata, exp);
  endtask

  task automatic rd_chk(input string name, input logic [29:0] a, input logic [63:0] exp);
    logic [63:0] g;
    cra_read(name, a, exp, 1'b1, g);
  endtask

  task automatic pulse_item();
    item_done = 1'b1;
    @(posedge clk); #1;
    item_done = 1'b0;
  endtask

  initial begin
    logic [63:0] got;
    int s, bad_wr, bad_vld;

    tbl[0]  = '{0, 30'h38, 64'd0, 8'h00, ID};
    tbl[1]  = '{0, 30'h40, 64'd0, 8'h00, 64'd0};
    tbl[2]  = '{1, 30'h28, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'd0};
    tbl[3]  = '{0, 30'h28, 64'd0, 8'h00, 64'h0000_0000_FFFF_FFFF};
    tbl[4]  = '{1, 30'h30, 64'h1234_5678_9ABC_DEF0, 8'hFF, 64'd0};
    tbl[5]  = '{0, 30'h30, 64'd0, 8'h00, 64'h1234_5678_9ABC_DEF0};
    tbl[6]  = '{1, 30'h10, 64'hFFFF_FFFF_0000_0005, 8'hFF, 64'd0};
    tbl[7]  = '{0, 30'h10, 64'd0, 8'h00, 64'h0000_0000_0000_0005};
    tbl[8]  = '{1, 30'h68, 64'd0, 8'hFF, 64'd0};
    tbl[9]  = '{0, 30'h28, 64'd0, 8'h00, 64'h0000_0000_FFFF_FFFF};
    tbl[10] = '{0, 30'h3C, 64'd0, 8'h00, ID};
    tbl[11] = '{1, 30'h00, 64'd2, 8'h00, 64'd0};
    tbl[12] = '{0, 30'h00, 64'd0, 8'h00, 64'd0};
    tbl[13] = '{1, 30'h00, 64'd2, 8'h01, 64'd0};
    tbl[14] = '{0, 30'h00, 64'd0, 8'h00, 64'd2};
    tbl[15] = '{0, 30'h08, 64'd0, 8'h00, 64'd0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_waitreq", {63'd0, waitreq}, 64'd1);
    chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_irq", {63'd0, irq}, 64'd0);
    chk("rst_kstart", {63'd0, kstart}, 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("waitreq_release", {63'd0, waitreq}, 64'd0);

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].is_wr) cra_write(tbl[i].a, tbl[i].d, tbl[i].b);
      else rd_chk($sformatf("tbl%0d", i), tbl[i].a, tbl[i].exp);
    end
    rd_chk("cycle_rst", 30'h18, 64'd0);
    rd_chk("completed_rst", 30'h20, 64'd0);

    // Back-to-back reads, responses in order on consecutive cycles
    wait_ready();
    addr = 30'h28; rd = 1'b1;
    @(posedge clk); #1;
    addr = 30'h38;
    @(posedge clk); #1;
    rd = 1'b0;
    chk("b2b_vld0", {63'd0, rvalid}, 64'd1);
    chk("b2b_data0", rdata, 64'h0000_0000_FFFF_FFFF);
    @(posedge clk); #1;
    chk("b2b_vld1", {63'd0, rvalid}, 64'd1);
    chk("b2b_data1", rdata, ID);
    @(posedge clk); #1;
    chk("b2b_vld2", {63'd0, rvalid}, 64'd0);

    // Run of 3 items with IRQ enabled
    cra_write(30'h10, 64'd3, 8'hFF);
    s = start_cnt;
    cra_write(30'h00, 64'd3, 8'h01);
    chk("run_kstart_hi", {63'd0, kstart}, 64'd1);
    @(posedge clk); #1;
    chk("run_kstart_lo", {63'd0, kstart}, 64'd0);
    rd_chk("run_busy", 30'h08, 64'd1);
    pulse_item();
    pulse_item();
    rd_chk("run_completed2", 30'h20, 64'd2);
    cra_write(30'h00, 64'd3, 8'h01);
    rd_chk("run_start_ignored", 30'h20, 64'd2);
    pulse_item();
    chk("run_irq_m1", {63'd0, irq}, 64'd0);
    @(posedge clk); #1;
    chk("run_irq_m2", {63'd0, irq}, 64'd1);
    rd_chk("run_status_done", 30'h08, 64'd2);
    rd_chk("run_completed3", 30'h20, 64'd3);
    chk("run_one_pulse", 64'(start_cnt - s), 64'd1);
    cra_read("run_cycles", 30'h18, 64'd0, 1'b0, got);
    chk("run_cycles_nonzero", {63'd0, (got != 64'd0)}, 64'd1);
    cra_write(30'h08, 64'd2, 8'h01);
    chk("w1c_irq_still", {63'd0, irq}, 64'd1);
    @(posedge clk); #1;
    chk("w1c_irq_clear", {63'd0, irq}, 64'd0);
    rd_chk("w1c_status", 30'h08, 64'd0);

    // WORK_SIZE = 0
    cra_write(30'h10, 64'd0, 8'hFF);
    s = start_cnt;
    cra_write(30'h00, 64'd3, 8'h01);
    chk("ws0_no_kstart", {63'd0, kstart}, 64'd0);
    rd_chk("ws0_status", 30'h08, 64'd2);
    chk("ws0_no_pulse", 64'(start_cnt - s), 64'd0);
    cra_write(30'h08, 64'd2, 8'h01);

    // SOFT_RST colliding with item_done in a run of 5
    cra_write(30'h10, 64'd5, 8'hFF);
    cra_write(30'h00, 64'd3, 8'h01);
    pulse_item();
    pulse_item();
    wait_ready();
    addr = 30'h00; wdata = 64'h6; be = 8'h01; wr = 1'b1; item_done = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0; item_done = 1'b0;
    rd_chk("srst_status", 30'h08, 64'd0);
    rd_chk("srst_completed", 30'h20, 64'd0);
    rd_chk("srst_cycles", 30'h18, 64'd0);
    rd_chk("srst_arg0", 30'h28, 64'h0000_0000_FFFF_FFFF);
    rd_chk("srst_ctrl", 30'h00, 64'd2);
    rd_chk("srst_ws", 30'h10, 64'd5);
    pulse_item();
    rd_chk("idle_item_ignored", 30'h20, 64'd0);

    // Freeze with a read in flight
    wait_ready();
    addr = 30'h30; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0; freeze = 1'b1;
    @(posedge clk); #1;
    chk("frz_waitreq", {63'd0, waitreq}, 64'd1);
    chk("frz_inflight_vld", {63'd0, rvalid}, 64'd1);
    chk("frz_inflight_data", rdata, 64'h1234_5678_9ABC_DEF0);
    addr = 30'h38; rd = 1'b1;
    bad_wr = 0; bad_vld = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!waitreq) bad_wr++;
      if (rvalid) bad_vld++;
    end
    chk("frz_held", 64'(bad_wr), 64'd0);
    chk("frz_no_resp", 64'(bad_vld), 64'd0);
    rd = 1'b0; freeze = 1'b0;
    @(posedge clk); #1;
    chk("frz_release", {63'd0, waitreq}, 64'd0);
    rd_chk("frz_after", 30'h38, ID);

    // Reset mid-run discards a pending response
    cra_write(30'h00, 64'd3, 8'h01);
    wait_ready();
    addr = 30'h38; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0; resetn = 1'b0;
    @(posedge clk); #1;
    chk("mrst_rvalid", {63'd0, rvalid}, 64'd0);
    chk("mrst_waitreq", {63'd0, waitreq}, 64'd1);
    chk("mrst_rdata", rdata, 64'd0);
    chk("mrst_kstart", {63'd0, kstart}, 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    rd_chk("mrst_ws", 30'h10, 64'd0);
    rd_chk("mrst_status", 30'h08, 64'd0);
    rd_chk("mrst_arg0", 30'h28, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/kernel_cra_responder.md
# kernel_cra_responder

Avalon-MM responder for the kernel control/status (CRA) port, on the kernel side of the board-to-kernel CRA link. It decodes single-beat 64-bit reads and writes into a small register file, sequences one kernel invocation through an IDLE/RUNNING/DONE state machine and raises the kernel interrupt on completion. It sits between the board's CRA initiator and the kernel compute datapath, which it drives through a start pulse and an item-done return.

## Interface
- ID_VALUE, 64'h4F43_4C5F_4352_4131: constant returned by the ID register.
- WORK_WIDTH, 32: width of WORK_SIZE and COMPLETED (1..64).
- kernel_clk_clk  in  1  sole clock; everything is synchronous to its rising edge.
- kernel_reset_reset_n  in  1  reset; synchronous, active-low.
- opencl_freeze  in  1  when high, holds off all CRA transfers.
- kernel_cra_address  in  30  byte address; bits [5:3] select the word, bits [2:0] are ignored.
- kernel_cra_read / kernel_cra_write  in  1  transfer requests.
- kernel_cra_writedata  in  64  write data.
- kernel_cra_byteenable  in  8  per-byte write enable.
- kernel_cra_burstcount  in  1  always 1; ignored.
- kernel_cra_debugaccess  in  1  ignored.
- kernel_cra_waitrequest  out  1  stall; a transfer is accepted when request is high and waitrequest is low.
- kernel_cra_readdata  out  64  read data.
- kernel_cra_readdatavalid  out  1  read response strobe.
- kernel_irq_irq  out  1  completion interrupt.
- kernel_start  out  1  one-cycle pulse to the datapath.
- kernel_item_done  in  1  one pulse per completed work item.

## Operation
- Register map (byte offset):
  - 0x00 CTRL: bit0 START (write 1 to start, self-clearing); bit1 IRQ_EN (RW); bit2 SOFT_RST (write 1, self-clearing). START and SOFT_RST read as 0.
  - 0x08 STATUS: bit0 BUSY (RO); bit1 DONE (write 1 to clear); other bits 0.
  - 0x10 WORK_SIZE: RW in [WORK_WIDTH-1:0]; upper bits read 0.
  - 0x18 CYCLE_COUNT: RO, 64-bit count of cycles spent in RUNNING; saturates at all-ones.
  - 0x20 COMPLETED: RO count of item-done pulses in the current run.
  - 0x28 ARG0 and 0x30 ARG1: RW 64-bit.
  - 0x38 ID: RO, returns ID_VALUE.
- Address bits [29:6] nonzero: reads return 0 and writes are ignored.
- Every RW field honours byteenable per byte. Control bits act only when their byte (byte 0) is enabled.
- State machine:
  - IDLE: a START write sets COMPLETED=0 and CYCLE_COUNT=0, pulses kernel_start, and moves to RUNNING. If WORK_SIZE=0, it moves to DONE instead and does not pulse kernel_start.
  - RUNNING: each kernel_item_done increments COMPLETED. When COMPLETED reaches WORK_SIZE, move to DONE. START writes here are ignored. BUSY=1.
  - DONE: sets STATUS.DONE, then returns to IDLE next cycle. DONE stays set until cleared by W1C or SOFT_RST.
- kernel_item_done outside RUNNING is ignored.
- kernel_irq_irq = DONE & IRQ_EN, registered.
- SOFT_RST returns the FSM to IDLE and clears DONE, COMPLETED and CYCLE_COUNT. ARG0, ARG1, WORK_SIZE and IRQ_EN are kept.
- Simultaneous events:
  - SOFT_RST beats item_done and START.
  - DONE set beats a W1C in the same cycle.
  - Read and write in the same cycle: the write is performed and the read is dropped (no readdatavalid).

## Timing
- Reset values: waitrequest=1, readdatavalid=0, readdata=0, irq=0, kernel_start=0, FSM=IDLE, all registers 0.
- waitrequest is registered. It is high in reset and while opencl_freeze is high. It drops in the first cycle after reset release when freeze is low.
- Read accepted in cycle N gives readdatavalid in N+2 with data sampled at end of N. Fully pipelined: one read per cycle, responses in order.
- Write accepted in N updates the register at end of N. A read accepted in N+1 returns the new value.
- START accepted in N: kernel_start=1 in N+1, BUSY=1 in N+1.
- The last item_done in cycle M: DONE=1 in M+1 and the FSM is in DONE; irq=1 in M+2.
- Reset asserted mid-run: by the next edge, all state is at reset values and any pending readdatavalid is discarded.
- Freeze rising while reads are in flight: the in-flight responses still complete.

## Test plan
- Reset, then read ID at 0x38 -> readdatavalid 2 cycles after acceptance, data 64'h4F43_4C5F_4352_4131. Read at 0x40 -> data 0.
- Write ARG0=64'hFFFF_FFFF_FFFF_FFFF with byteenable 8'h0F, then read -> 64'h0000_0000_FFFF_FFFF. Back-to-back reads of ARG0 and ID -> two consecutive valids in order.
- WORK_SIZE=3, IRQ_EN=1, START, three item_done pulses -> kernel_start pulse, BUSY=1, COMPLETED=3, DONE=1, irq=1 two cycles after the last pulse. W1C DONE -> irq=0.
- WORK_SIZE=0 with START -> no kernel_start pulse, DONE=1 next cycle. A START while RUNNING -> ignored, COMPLETED unchanged.
- SOFT_RST in the same cycle as an item_done during a run of 5 -> FSM=IDLE, COMPLETED=0, ARG0 retained.
- Freeze high for 10 cycles -> waitrequest=1 and no acceptances; a read issued 1 cycle before freeze still returns readdatavalid.
